normalize_round: RTL and testbench
==================================

Name: normalize_round

Overview:
- Stage directly downstream of the mantissa adder in the half-precision (1/5/10) add datapath.
- Consumes the raw sum, carry-out, sticky flag, sign and larger operand exponent, and normalises the result.
- Normalisation is iterative: one left-shift per cycle for leading zeros, or one right-shift on carry.
- Applies round-to-nearest-even, handles exponent overflow and subnormal results, and emits a packed 16-bit word.
- Uses valid/ready handshakes on both sides.

Parameters:
- EXP_W, 5, exponent field width
- MAN_W, 10, stored fraction width; internal significand is MAN_W+1 bits (hidden bit at MSB)
- EXP_MAX, 31, all-ones exponent (Inf/NaN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream holds a result
- in_ready  out  1  block can accept (IDLE only)
- in_sign  in  1  result sign
- in_exp  in  5  larger operand biased exponent
- in_carry  in  1  adder carry-out (sum bit 11)
- in_mant  in  11  adder sum bits [10:0]; bit 10 is the hidden-bit position
- in_sticky  in  1  OR of bits lost during alignment
- out_valid  out  1  packed result available
- out_ready  in  1  consumer takes the result
- out_result  out  16  {sign, exp[4:0], frac[9:0]}
- out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - out_valid=0, out_result=16'h0000, out_inexact=0.
  - in_ready=1 once rst deasserts.
  - All internal registers are cleared.
- Reset mid-operation: asserting rst in any state aborts the operation immediately. No output is produced for the aborted operation.
- Acceptance: a transfer occurs when in_valid & in_ready at a rising edge. The block latches sign, exp, carry, mant and sticky, clears the round bit, and moves to NORM.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On acceptance, go to NORM.
- NORM: evaluate in priority order.
  1. If exp==EXP_MAX: pass through as Inf/NaN. frac = mant[9:0], round skipped, go to DONE.
  2. Else if carry: mant={1,mant[10:1]}, round=old mant[0], exp+=1, go to ROUND. Only one cycle is spent in NORM.
  3. Else if mant==0: result is +0 (sign forced 0), go to DONE.
  4. Else if mant[10]==0 and exp>1: shift mant left 1 with zero fill, exp-=1, stay in NORM (one shift per cycle).
  5. Else if mant[10]==0 and exp<=1: the result is subnormal. Packed exp=0, go to ROUND.
  6. Else (normalised): go to ROUND.
- Exponent convention: an input with in_exp==0 is treated as exponent 1 for arithmetic. A carry from a subnormal sum produces packed exp=1.
- ROUND: RNE increment = round & (sticky | mant[0]).
  - If the increment overflows mant to 2048: mant=1024, exp+=1.
  - If the final exp>=EXP_MAX: result is Inf = {sign,5'h1F,10'h000}, out_inexact=1.
  - Otherwise out_inexact = round|sticky.
  - Go to DONE.
- DONE: out_valid=1 and out_result is held stable until out_ready. On out_valid&out_ready, go to IDLE (in_ready=1 the next cycle; no same-cycle accept).
- Latency, counted in rising edges from acceptance to out_valid:
  - Normalised or carry input: 3.
  - Each left-shift adds 1.
  - Zero or Inf/NaN input: 2.
- Backpressure: out_ready=0 holds DONE indefinitely. in_ready stays 0 the whole time.
- Width rule: exp is held internally as 6 bits so that overflow past 31 is detectable.

Decomposition:
- Shared package fp16_pkg:
  - EXP_W, MAN_W, EXP_MAX, BIAS=15
  - State enum (IDLE/NORM/ROUND/DONE)
  - Packing helper constants: QNAN 16'h7E00, PINF 16'h7C00
- The rounding increment plus overflow fix-up is combinational and reusable. Place it in sub-module rne_incr (inputs mant, round, sticky, exp; outputs new mant, new exp, inexact).

Test Plan:
1. Carry to a power of two: exp=15, carry=1, mant=0x000, sticky=0 → out_result=16'h4000 (2.0), out_inexact=0, out_valid 3 edges after accept.
2. Rounding, tie and above-tie:
   - carry=1, mant=0x401, exp=15, sticky=0 → tie to even, 16'h4200, inexact=1.
   - Same input with sticky=1 → 16'h4201.
3. Left normalisation: exp=15, carry=0, mant=0x080 → 3 shifts → 16'h3000, out_valid 6 edges after accept.
   - Same input with exp=2 → stops at exp=1, subnormal → 16'h0100.
4. Overflow: exp=30, carry=1, mant=0x7FF, sticky=1, sign=1 → 16'hFC00, inexact=1.
   - exp=31, mant=0x200 → passes through as 16'h7E00.
5. Zero and backpressure: carry=0, mant=0, sign=1 → 16'h0000. Hold out_ready=0 for 5 cycles → out_result stable, in_ready=0. Then out_ready=1 → IDLE.
6. Async reset: assert rst mid-NORM, between clock edges → out_valid=0 and in_ready=0 immediately. After release, in_ready=1 and no stale output appears.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision (1/5/10) add datapath.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int EXP_MAX = 31;
    localparam int BIAS    = 15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_e;

endpackage

// File: rtl/rne_incr.sv
// Round-to-nearest-even increment with significand overflow and exponent fix-up.
module rne_incr
    import fp16_pkg::*;
(
    input  logic [MAN_W:0] mant_i,
    input  logic           round_i,
    input  logic           sticky_i,
    input  logic [EXP_W:0] exp_i,
    output logic [MAN_W:0] mant_o,
    output logic [EXP_W:0] exp_o,
    output logic           inexact_o
);

    localparam logic [EXP_W:0] EXP_INF = (EXP_W+1)'(EXP_MAX);

    logic           incr;
    logic [MAN_W+1:0] sum;

    // NOTE: every output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        incr      = round_i & (sticky_i | mant_i[0]);
        sum       = {1'b0, mant_i} + {{(MAN_W+1){1'b0}}, incr};
        mant_o    = sum[MAN_W:0];
        exp_o     = exp_i;
        if (sum[MAN_W+1]) begin
            mant_o = {1'b1, {MAN_W{1'b0}}};
            exp_o  = exp_i + 1'b1;
        end else if (exp_i == '0 && sum[MAN_W]) begin
            // A subnormal rounded up into the hidden bit becomes the smallest normal.
            exp_o = (EXP_W+1)'(1);
        end
        inexact_o = round_i | sticky_i | (exp_o >= EXP_INF);
    end

endmodule

// File: rtl/normalize_round.sv
// Iterative normaliser and RNE rounder following the fp16 mantissa adder.
module normalize_round
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_carry,
    input  logic [MAN_W:0]   in_mant,
    input  logic             in_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_inexact
);

    localparam logic [EXP_W:0] EXP_INF = (EXP_W+1)'(EXP_MAX);
    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

    state_e           state_q;
    logic             sign_q;
    logic [EXP_W:0]   exp_q;
    logic             carry_q;
    logic [MAN_W:0]   mant_q;
    logic             sticky_q;
    logic             round_q;
    logic             out_valid_q;
    logic [15:0]      out_result_q;
    logic             out_inexact_q;

    logic [MAN_W:0]   rnd_mant_d;
    logic [EXP_W:0]   rnd_exp_d;
    logic             rnd_inexact_d;

    rne_incr u_rne_incr (
        .mant_i    (mant_q),
        .round_i   (round_q),
        .sticky_i  (sticky_q),
        .exp_i     (exp_q),
        .mant_o    (rnd_mant_d),
        .exp_o     (rnd_exp_d),
        .inexact_o (rnd_inexact_d)
    );

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_inexact = out_inexact_q;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            carry_q       <= 1'b0;
            mant_q        <= '0;
            sticky_q      <= 1'b0;
            round_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        // A subnormal operand carries exponent 1 in arithmetic.
                        exp_q    <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
                        carry_q  <= in_carry;
                        mant_q   <= in_mant;
                        sticky_q <= in_sticky;
                        round_q  <= 1'b0;
                        state_q  <= NORM;
                    end
                end
                NORM: begin
                    if (exp_q == EXP_INF) begin
                        out_result_q  <= {sign_q, exp_q[EXP_W-1:0], mant_q[MAN_W-1:0]};
                        out_inexact_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end else if (carry_q) begin
                        mant_q  <= {1'b1, mant_q[MAN_W:1]};
                        round_q <= mant_q[0];
                        exp_q   <= exp_q + 1'b1;
                        carry_q <= 1'b0;
                        state_q <= ROUND;
                    end else if (mant_q == '0) begin
                        out_result_q  <= '0;
                        out_inexact_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end else if (!mant_q[MAN_W] && exp_q > EXP_ONE) begin
                        mant_q <= {mant_q[MAN_W-1:0], 1'b0};
                        exp_q  <= exp_q - 1'b1;
                    end else if (!mant_q[MAN_W]) begin
                        exp_q   <= '0;
                        state_q <= ROUND;
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (rnd_exp_d >= EXP_INF) begin
                        out_result_q <= {sign_q, PINF[14:0]};
                    end else begin
                        out_result_q <= {sign_q, rnd_exp_d[EXP_W-1:0], rnd_mant_d[MAN_W-1:0]};
                    end
                    out_inexact_q <= rnd_inexact_d;
                    out_valid_q   <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_round.sv
// Directed-vector bench for normalize_round: table of rounding cases plus reset and backpressure sequences.
module tb_normalize_round;

    typedef struct {
        logic        sign;
        logic [4:0]  exp;
        logic        carry;
        logic [10:0] mant;
        logic        sticky;
        logic [15:0] res;
        logic        inexact;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic        in_carry;
    logic [10:0] in_mant;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;

    vec_t vecs[12];

    normalize_round dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_carry    (in_carry),
        .in_mant     (in_mant),
        .in_sticky   (in_sticky),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        @(negedge clk);
        in_sign   = v.sign;
        in_exp    = v.exp;
        in_carry  = v.carry;
        in_mant   = v.mant;
        in_sticky = v.sticky;
        in_valid  = 1'b1;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        send(v);
        wait_out(lat);
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_result"}, 32'(out_result), 32'(v.res));
        check({tag, "_inexact"}, 32'(out_inexact), 32'(v.inexact));
        repeat (2) begin
            @(posedge clk);
            #1;
            check({tag, "_held"}, 32'(out_result), 32'(v.res));
        end
        release_out(tag);
    endtask

    initial begin
        int   lat;
        int   stale;
        vec_t zero_v;
        vec_t shift_v;

        //             sign  exp    carry mant     sticky result    inexact lat
        vecs[0]  = '{1'b0, 5'd15, 1'b1, 11'h000, 1'b0, 16'h4000, 1'b0, 3};
        vecs[1]  = '{1'b0, 5'd15, 1'b1, 11'h401, 1'b0, 16'h4200, 1'b1, 3};
        vecs[2]  = '{1'b0, 5'd15, 1'b1, 11'h401, 1'b1, 16'h4201, 1'b1, 3};
        vecs[3]  = '{1'b0, 5'd15, 1'b0, 11'h080, 1'b0, 16'h3000, 1'b0, 6};
        vecs[4]  = '{1'b0, 5'd2,  1'b0, 11'h080, 1'b0, 16'h0100, 1'b0, 4};
        vecs[5]  = '{1'b1, 5'd30, 1'b1, 11'h7FF, 1'b1, 16'hFC00, 1'b1, 3};
        vecs[6]  = '{1'b0, 5'd31, 1'b0, 11'h200, 1'b0, 16'h7E00, 1'b0, 2};
        vecs[7]  = '{1'b0, 5'd10, 1'b0, 11'h555, 1'b1, 16'h2955, 1'b1, 3};
        vecs[8]  = '{1'b0, 5'd0,  1'b0, 11'h0FF, 1'b0, 16'h00FF, 1'b0, 3};
        vecs[9]  = '{1'b0, 5'd0,  1'b0, 11'h400, 1'b0, 16'h0400, 1'b0, 3};
        vecs[10] = '{1'b0, 5'd15, 1'b1, 11'h403, 1'b0, 16'h4202, 1'b1, 3};
        vecs[11] = '{1'b0, 5'd30, 1'b1, 11'h000, 1'b0, 16'h7C00, 1'b1, 3};
        zero_v   = '{1'b1, 5'd12, 1'b0, 11'h000, 1'b0, 16'h0000, 1'b0, 2};
        shift_v  = vecs[3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_carry  = 1'b0;
        in_mant   = '0;
        in_sticky = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_out_inexact", 32'(out_inexact), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Zero result with sign forced positive, then sustained backpressure.
        send(zero_v);
        wait_out(lat);
        check("zero_latency", 32'(lat), 32'd2);
        check("zero_result", 32'(out_result), 32'h0000);
        check("zero_inexact", 32'(out_inexact), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(out_result), 32'h0000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        release_out("bp");

        // Asynchronous reset while the shifter is busy in NORM.
        send(shift_v);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) stale++;
        end
        check("arst_no_stale", 32'(stale), 32'd0);
        run_vec(vecs[2], 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
